hazard_ctrl: RTL and testbench

Pipeline hazard and stall sequencer for the five-stage MIPS core. It sits beside `controlUnit` and drives the write-enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves these hazards, one cycle at a time:
- load-use hazards
- taken-branch and jump redirects
- reads of HI/LO while the multi-cycle multiply/divide unit is busy
- data-memory wait states

It also keeps saturating performance counters for stalls and flushes.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/md_busy_counter.sv | 32 +++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: sequencer state
// encoding and the architectural zero-register index.
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/md_busy_counter.sv
// Tracks the outstanding multiply/divide latency: loads on issue, counts down
// every cycle, and flags busy while the HI/LO result is still pending.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  localparam int CW = $clog2(MD_LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY);

  logic [CW-1:0] count;

  // A new issue while busy simply restarts the full latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall sequencer: drives the PC and pipeline-register
// enables/flushes, tracks memory wait states and keeps stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY  = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_md_read,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             state
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  state_t            state_q;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_next;
  logic              freeze;
  logic              lu;
  logic              mds;
  logic              md_pending;

  assign freeze = mem_req & ~dmem_ready;
  assign lu     = ex_mem_read & (ex_rd != REG_ZERO) &
                  ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  assign md_busy = md_pending & ~rst;
  assign mds     = id_md_read & md_busy;
  assign state   = state_q;

  // A start seen while frozen is dropped; the EX stage still holds it and
  // presents it again on the first unfrozen cycle.
  md_busy_counter #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_busy_counter (
    .clk (clk),
    .rst (rst),
    .load(ex_md_start & ~freeze),
    .busy(md_pending)
  );

  // Priority mux: freeze > taken branch > load-use / HI-LO stall > jump.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    exmem_we   = 1'b1;
    memwb_we   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        memwb_we = 1'b0;
      end else if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu | mds) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  // wcnt counts consecutive frozen cycles and saturates at the timeout.
  always_comb begin
    wcnt_next = '0;
    if (freeze) begin
      wcnt_next = (wcnt == WCNT_MAX) ? WCNT_MAX : wcnt + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state_q)
        RUN:     if (freeze)  state_q <= WAIT;
        WAIT:    if (!freeze) state_q <= RUN;
        default: state_q <= RUN;
      endcase
      wcnt <= wcnt_next;
      if (wcnt_next == WCNT_MAX) begin
        mem_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_we && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if ((ifid_flush | idex_flush) && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with fixed
// expectations plus a randomized run against a cycle-level reference model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MD_L = 4;
  localparam int TO   = 3;
  localparam int CW   = 6;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rd;
  logic          id_uses_rt, id_jump, id_md_read, ex_mem_read;
  logic          ex_branch_taken, ex_md_start, mem_req, dmem_ready;
  logic          pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic          ifid_flush, idex_flush, md_busy, mem_err, state;
  logic [CW-1:0] stall_cycles, flush_events;
  logic [6:0]    dut_ctl;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint cyc = 0;
  bit     have_start = 0;
  longint start_cyc = 0;
  int     frz_run = 0;
  bit     m_err = 0;
  bit     m_prev_frz = 0;
  int     m_stall = 0;
  int     m_flush = 0;

  hazard_ctrl #(.MD_LATENCY(MD_L), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_md_read(id_md_read), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .pc_we(pc_we), .ifid_we(ifid_we),
    .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .md_busy(md_busy),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .state(state)
  );

  assign dut_ctl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush};

  always #5 clk = ~clk;

  function automatic bit exp_busy();
    return !rst && have_start && (cyc > start_cyc) && (cyc <= start_cyc + MD_L);
  endfunction

  // Expected {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush}
  function automatic logic [6:0] exp_ctl();
    bit frz, lu_h;
    frz  = mem_req && !dmem_ready;
    lu_h = ex_mem_read && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    if (rst) return 7'b1111100;
    if (frz) return 7'b0000000;
    if (ex_branch_taken) return 7'b1111111;
    if (lu_h || (id_md_read && exp_busy())) return 7'b0011101;
    if (id_jump) return 7'b1111110;
    return 7'b1111100;
  endfunction

  function automatic logic [CW-1:0] sat(int v);
    return CW'((v > SAT) ? SAT : v);
  endfunction

  task automatic model_edge();
    logic [6:0] c;
    bit frz;
    c   = exp_ctl();
    frz = mem_req && !dmem_ready;
    if (rst) begin
      have_start = 0; frz_run = 0; m_err = 0; m_prev_frz = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (ex_md_start && !frz) begin
        have_start = 1;
        start_cyc  = cyc;
      end
      frz_run = frz ? frz_run + 1 : 0;
      if (frz_run >= TO) m_err = 1;
      m_prev_frz = frz;
      if (!c[6]) m_stall++;
      if (c[1] || c[0]) m_flush++;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rt = 0; id_jump = 0; id_md_read = 0;
    ex_mem_read = 0; ex_branch_taken = 0; ex_md_start = 0; mem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    mem_req = 1; ex_md_start = 1; ex_branch_taken = 1;
    @(negedge clk);
    checks++; if (dut_ctl !== 7'b1111100) begin errors++; $display("FAIL reset_ctl got=%b exp=1111100", dut_ctl); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
    tick(); tick();
    rst = 0; clear_inputs();
    @(negedge clk);
    checks++; if (stall_cycles !== 0 || flush_events !== 0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_events); end
    checks++; if (mem_err !== 1'b0 || md_busy !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", mem_err, md_busy); end
    checks++; if (state !== RUN) begin errors++; $display("FAIL reset_state got=%b exp=%b", state, RUN); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_rs = 5;
    @(negedge clk);
    checks++; if (dut_ctl !== 7'b0011101) begin errors++; $display("FAIL lu_stall got=%b exp=0011101", dut_ctl); end
    tick();
    ex_mem_read = 0;
    @(negedge clk);
    checks++; if (dut_ctl !== 7'b1111100) begin errors++; $display("FAIL lu_release got=%b exp=1111100", dut_ctl); end
    checks++; if (stall_cycles !== 1 || flush_events !== 1) begin errors++; $display("FAIL lu_cnt got=%0d/%0d exp=1/1", stall_cycles, flush_events); end
    ex_mem_read = 1; ex_rd = 0; id_rs = 0;
    @(negedge clk);
    checks++; if (dut_ctl !== 7'b1111100) begin errors++; $display("FAIL lu_r0 got=%b exp=1111100", dut_ctl); end
    ex_rd = 7; id_rt = 7; id_rs = 1; id_uses_rt = 0;
    #1;
    checks++; if (dut_ctl !== 7'b1111100) begin errors++; $display("FAIL lu_rt_unused got=%b exp=1111100", dut_ctl); end
    id_uses_rt = 1;
    #1;
    checks++; if (dut_ctl !== 7'b0011101) begin errors++; $display("FAIL lu_rt got=%b exp=0011101", dut_ctl); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    ex_mem_read = 1; ex_rd = 9; id_rs = 9; ex_branch_taken = 1;
    @(negedge clk);
    checks++; if (dut_ctl !== 7'b1111111) begin errors++; $display("FAIL br_beats_lu got=%b exp=1111111", dut_ctl); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (flush_events !== 1 || stall_cycles !== 0) begin errors++; $display("FAIL br_cnt got=%0d/%0d exp=1/0", flush_events, stall_cycles); end
    tick();
  endtask

  task automatic test_jump_vs_lu();
    do_reset();
    id_jump = 1; ex_mem_read = 1; ex_rd = 3; id_rt = 3; id_uses_rt = 1;
    @(negedge clk);
    checks++; if (dut_ctl !== 7'b0011101) begin errors++; $display("FAIL jmp_lu got=%b exp=0011101", dut_ctl); end
    tick();
    ex_mem_read = 0;
    @(negedge clk);
    checks++; if (dut_ctl !== 7'b1111110) begin errors++; $display("FAIL jmp_retry got=%b exp=1111110", dut_ctl); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (stall_cycles !== 1 || flush_events !== 2) begin errors++; $display("FAIL jmp_cnt got=%0d/%0d exp=1/2", stall_cycles, flush_events); end
    tick();
  endtask

  task automatic test_md_busy();
    do_reset();
    ex_md_start = 1;
    @(negedge clk);
    checks++; if (md_busy !== 1'b0 || dut_ctl !== 7'b1111100) begin errors++; $display("FAIL md_issue got=%b/%b exp=0/1111100", md_busy, dut_ctl); end
    tick();
    ex_md_start = 0; id_md_read = 1;
    for (int i = 0; i < MD_L; i++) begin
      @(negedge clk);
      checks++; if (md_busy !== 1'b1 || dut_ctl !== 7'b0011101) begin errors++; $display("FAIL md_stall%0d got=%b/%b exp=1/0011101", i, md_busy, dut_ctl); end
      tick();
    end
    @(negedge clk);
    checks++; if (md_busy !== 1'b0 || dut_ctl !== 7'b1111100) begin errors++; $display("FAIL md_release got=%b/%b exp=0/1111100", md_busy, dut_ctl); end
    checks++; if (stall_cycles !== MD_L) begin errors++; $display("FAIL md_cnt got=%0d exp=%0d", stall_cycles, MD_L); end
    id_md_read = 0; ex_md_start = 1;
    tick();
    ex_md_start = 0;
    tick(); tick();
    ex_md_start = 1;
    tick();
    ex_md_start = 0;
    for (int i = 0; i < MD_L; i++) begin
      @(negedge clk);
      checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL md_reload%0d got=%b exp=1", i, md_busy); end
      tick();
    end
    @(negedge clk);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md_reload_end got=%b exp=0", md_busy); end
    mem_req = 1; dmem_ready = 0; ex_md_start = 1;
    tick();
    mem_req = 0;
    @(negedge clk);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md_frozen_start got=%b exp=0", md_busy); end
    tick();
    ex_md_start = 0;
    @(negedge clk);
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL md_late_start got=%b exp=1", md_busy); end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      ex_branch_taken = (i == 3);
      @(negedge clk);
      checks++; if (dut_ctl !== 7'b0000000) begin errors++; $display("FAIL wait_ctl%0d got=%b exp=0000000", i, dut_ctl); end
      checks++; if (state !== ((i == 1) ? RUN : WAIT)) begin errors++; $display("FAIL wait_state%0d got=%b", i, state); end
      checks++; if (mem_err !== (i >= 4)) begin errors++; $display("FAIL wait_err%0d got=%b exp=%b", i, mem_err, (i >= 4)); end
      tick();
    end
    ex_branch_taken = 0; dmem_ready = 1;
    @(negedge clk);
    checks++; if (dut_ctl !== 7'b1111100 || mem_err !== 1'b1) begin errors++; $display("FAIL wait_done got=%b/%b exp=1111100/1", dut_ctl, mem_err); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (state !== RUN || mem_err !== 1'b1) begin errors++; $display("FAIL wait_sticky got=%b/%b exp=%b/1", state, mem_err, RUN); end
    checks++; if (stall_cycles !== 5 || flush_events !== 0) begin errors++; $display("FAIL wait_cnt got=%0d/%0d exp=5/0", stall_cycles, flush_events); end
    do_reset();
    @(negedge clk);
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL wait_rst got=%b exp=0", mem_err); end
    for (int r = 0; r < 2; r++) begin
      mem_req = 1; dmem_ready = 0;
      tick(); tick();
      dmem_ready = 1;
      tick();
    end
    @(negedge clk);
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL wait_split got=%b exp=0", mem_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ex_md_start = 1;
    tick();
    ex_md_start = 0; mem_req = 1; dmem_ready = 0;
    tick(); tick();
    @(negedge clk);
    checks++; if (md_busy !== 1'b1 || state !== WAIT) begin errors++; $display("FAIL mid_pre got=%b/%b exp=1/%b", md_busy, state, WAIT); end
    rst = 1;
    @(negedge clk);
    checks++; if (dut_ctl !== 7'b1111100 || md_busy !== 1'b0) begin errors++; $display("FAIL mid_rst got=%b/%b exp=1111100/0", dut_ctl, md_busy); end
    tick();
    rst = 0; clear_inputs();
    @(negedge clk);
    checks++; if (md_busy !== 1'b0 || state !== RUN) begin errors++; $display("FAIL mid_post got=%b/%b exp=0/%b", md_busy, state, RUN); end
    checks++; if (stall_cycles !== 0 || flush_events !== 0 || dut_ctl !== 7'b1111100) begin errors++; $display("FAIL mid_cnt got=%0d/%0d/%b exp=0/0/1111100", stall_cycles, flush_events, dut_ctl); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_rs = 5;
    repeat (SAT + 7) tick();
    @(negedge clk);
    checks++; if (stall_cycles !== CW'(SAT) || flush_events !== CW'(SAT)) begin errors++; $display("FAIL sat got=%0d/%0d exp=%0d", stall_cycles, flush_events, SAT); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst             = ($urandom_range(0, 149) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rt      = $urandom_range(0, 1) != 0;
      id_jump         = $urandom_range(0, 5) == 0;
      id_md_read      = $urandom_range(0, 2) == 0;
      ex_mem_read     = $urandom_range(0, 2) == 0;
      ex_branch_taken = $urandom_range(0, 7) == 0;
      ex_md_start     = $urandom_range(0, 9) == 0;
      mem_req         = $urandom_range(0, 2) == 0;
      dmem_ready      = $urandom_range(0, 3) == 0;
      @(negedge clk);
      checks++; if (dut_ctl !== exp_ctl()) begin errors++; $display("FAIL rnd_ctl n=%0d got=%b exp=%b", n, dut_ctl, exp_ctl()); end
      checks++; if (md_busy !== exp_busy()) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, md_busy, exp_busy()); end
      checks++; if (mem_err !== m_err || state !== m_prev_frz) begin errors++; $display("FAIL rnd_fsm n=%0d got=%b/%b exp=%b/%b", n, mem_err, state, m_err, m_prev_frz); end
      checks++; if (stall_cycles !== sat(m_stall) || flush_events !== sat(m_flush)) begin errors++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, stall_cycles, flush_events, sat(m_stall), sat(m_flush)); end
      tick();
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_jump_vs_lu();
    test_md_busy();
    test_mem_wait();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
